// File: rtl/sram_bridge_pkg.sv
// Shared types and constants for the STEAMER16X4 cellular-RAM bridge.
// State encoding, byte-lane constants and the wait counter width.
package sram_bridge_pkg;

    localparam int WAIT_W = 4;

    localparam logic [1:0] SEL_HI   = 2'b10;
    localparam logic [1:0] SEL_LO   = 2'b01;
    localparam logic [1:0] SEL_WORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2,
        ST_POST   = 2'd3
    } state_e;

    function automatic logic [15:0] lane_mask(input logic [1:0] sel);
        return {{8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/sramb_wait_ctr.sv
// Loadable down-counter with zero flag and synchronous clear,
// used to time how long the SRAM strobes stay asserted.
module sramb_wait_ctr
    import sram_bridge_pkg::*;
#(
    parameter int W = WAIT_W
) (
    input  logic         clk_i,
    input  logic         res_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (res_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sram_bridge_s16.sv
// Wishbone-classic responder driving the Nexys2 16-bit cellular RAM.
// Define SRAMB_POSTED_WRITE_EN to acknowledge writes early (posted).
module sram_bridge_s16
    import sram_bridge_pkg::*;
#(
    parameter int WAIT_STATES = 4,
    parameter int RAM_ADR_HI  = 23
) (
    input  logic                  clk_i,
    input  logic                  res_i,
    input  logic [14:0]           adr_i,
    input  logic                  we_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic [1:0]            sel_i,
    input  logic                  vda_i,
    input  logic                  vpa_i,
    input  logic [15:0]           dat_i,
    output logic                  ack_o,
    output logic [15:0]           dat_o,
    output logic [RAM_ADR_HI-1:0] sram_adr_o,
    output logic                  sram_ce_n_o,
    output logic                  sram_oe_n_o,
    output logic                  sram_we_n_o,
    output logic                  sram_ub_n_o,
    output logic                  sram_lb_n_o,
    output logic [15:0]           sram_dq_o,
    output logic                  sram_dq_oe_o,
    input  logic [15:0]           sram_dq_i
);

`ifdef SRAMB_POSTED_WRITE_EN
    localparam logic POSTED = 1'b1;
`else
    localparam logic POSTED = 1'b0;
`endif

    state_e      state_q, state_d;
    logic [14:0] adr_q, adr_d;
    logic        we_q, we_d;
    logic [1:0]  sel_q, sel_d;
    logic [15:0] wdat_q, wdat_d;
    logic        posted_q, posted_d;
    logic        abort_q, abort_d;
    logic        ack_q, ack_d;
    logic [15:0] dat_q, dat_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        ub_n_q, ub_n_d;
    logic        lb_n_q, lb_n_d;
    logic        dq_oe_q, dq_oe_d;
    logic [1:0]  dbg_unused_q;

    logic req;
    logic capture;
    logic cnt_load;
    logic cnt_dec;
    logic cnt_clr;
    logic cnt_zero;

    assign req = cyc_i & stb_i;

    sramb_wait_ctr #(
        .W(WAIT_W)
    ) u_wait_ctr (
        .clk_i     (clk_i),
        .res_i     (res_i),
        .clr_i     (cnt_clr),
        .load_i    (cnt_load),
        .load_val_i(WAIT_W'(WAIT_STATES)),
        .dec_i     (cnt_dec),
        .zero_o    (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        we_d     = we_q;
        sel_d    = sel_q;
        wdat_d   = wdat_q;
        posted_d = posted_q;
        abort_d  = abort_q;
        ack_d    = 1'b0;
        dat_d    = dat_q;
        ce_n_d   = ce_n_q;
        oe_n_d   = oe_n_q;
        we_n_d   = we_n_q;
        ub_n_d   = ub_n_q;
        lb_n_d   = lb_n_q;
        dq_oe_d  = dq_oe_q;
        capture  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_clr  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    capture  = 1'b1;
                    cnt_load = 1'b1;
                    adr_d    = adr_i;
                    we_d     = we_i;
                    sel_d    = sel_i;
                    wdat_d   = dat_i;
                    posted_d = POSTED & we_i;
                    abort_d  = 1'b0;
                    ce_n_d   = 1'b0;
                    ub_n_d   = ~sel_i[1];
                    lb_n_d   = ~sel_i[0];
                    oe_n_d   = we_i;
                    we_n_d   = ~we_i;
                    dq_oe_d  = we_i;
                    state_d  = (POSTED && we_i) ? ST_POST : ST_ACCESS;
                end
            end
            ST_POST, ST_ACCESS: begin
                // A posted write acknowledges on leaving POST; the SRAM
                // cycle then keeps running with no further bus dependency.
                if (state_q == ST_POST) begin
                    ack_d = 1'b1;
                end
                if (state_q == ST_ACCESS && !req && !posted_q) begin
                    abort_d = 1'b1;
                end
                if (cnt_zero) begin
                    state_d = ST_ACK;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    if (state_q == ST_ACCESS && !posted_q &&
                        !abort_q && req) begin
                        ack_d = 1'b1;
                        if (!we_q) begin
                            dat_d = sram_dq_i & lane_mask(sel_q);
                        end
                    end
                end else begin
                    cnt_dec = 1'b1;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                ub_n_d  = 1'b1;
                lb_n_d  = 1'b1;
                dq_oe_d = 1'b0;
                cnt_clr = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (res_i) begin
            state_q  <= ST_IDLE;
            adr_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            wdat_q   <= '0;
            posted_q <= 1'b0;
            abort_q  <= 1'b0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            ub_n_q   <= 1'b1;
            lb_n_q   <= 1'b1;
            dq_oe_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            wdat_q   <= wdat_d;
            posted_q <= posted_d;
            abort_q  <= abort_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            ub_n_q   <= ub_n_d;
            lb_n_q   <= lb_n_d;
            dq_oe_q  <= dq_oe_d;
        end
    end

    // Access qualifiers are kept only for probing with a logic analyser.
    always_ff @(posedge clk_i) begin
        if (res_i) begin
            dbg_unused_q <= '0;
        end else if (capture) begin
            dbg_unused_q <= {vda_i, vpa_i};
        end
    end

    assign ack_o        = ack_q;
    assign dat_o        = dat_q;
    assign sram_adr_o   = {{(RAM_ADR_HI - 15){1'b0}}, adr_q};
    assign sram_ce_n_o  = ce_n_q;
    assign sram_oe_n_o  = oe_n_q;
    assign sram_we_n_o  = we_n_q;
    assign sram_ub_n_o  = ub_n_q;
    assign sram_lb_n_o  = lb_n_q;
    assign sram_dq_o    = wdat_q;
    assign sram_dq_oe_o = dq_oe_q;

endmodule

// File: tb/tb_sram_bridge_s16.sv
// Self-checking bench for sram_bridge_s16 with a behavioural SRAM
// and a word-level memory model kept separately from the bus timing.
module tb_sram_bridge_s16;

    localparam int W = 4;
`ifdef SRAMB_POSTED_WRITE_EN
    localparam int WR_LAT = 2;
`else
    localparam int WR_LAT = W + 2;
`endif
    localparam int RD_LAT = W + 2;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic [14:0] adr = '0;
    logic        we = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic [1:0]  sel = '0;
    logic        vda = 1'b0;
    logic        vpa = 1'b0;
    logic [15:0] wdat = '0;
    logic        ack;
    logic [15:0] rdat;
    logic [22:0] s_adr;
    logic        ce_n, oe_n, we_n, ub_n, lb_n;
    logic [15:0] dq_o;
    logic        dq_oe;
    logic [15:0] dq_i;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_mem [int];

    sram_bridge_s16 #(
        .WAIT_STATES(W),
        .RAM_ADR_HI (23)
    ) dut (
        .clk_i       (clk),
        .res_i       (res),
        .adr_i       (adr),
        .we_i        (we),
        .cyc_i       (cyc),
        .stb_i       (stb),
        .sel_i       (sel),
        .vda_i       (vda),
        .vpa_i       (vpa),
        .dat_i       (wdat),
        .ack_o       (ack),
        .dat_o       (rdat),
        .sram_adr_o  (s_adr),
        .sram_ce_n_o (ce_n),
        .sram_oe_n_o (oe_n),
        .sram_we_n_o (we_n),
        .sram_ub_n_o (ub_n),
        .sram_lb_n_o (lb_n),
        .sram_dq_o   (dq_o),
        .sram_dq_oe_o(dq_oe),
        .sram_dq_i   (dq_i)
    );

    always #5 clk = ~clk;

    // Behavioural asynchronous SRAM
    logic [15:0] sram [0:32767];
    assign dq_i = (!ce_n && !oe_n) ? sram[s_adr[14:0]] : 16'hDEAD;
    always @(posedge clk) begin
        if (!ce_n && !we_n && dq_oe) begin
            if (!ub_n) sram[s_adr[14:0]][15:8] <= dq_o[15:8];
            if (!lb_n) sram[s_adr[14:0]][7:0]  <= dq_o[7:0];
        end
    end

    // Pin activity monitor
    int n_ce = 0, n_oe = 0, n_we = 0, n_ub = 0, n_lb = 0;
    int n_ack = 0, n_rise = 0;
    logic        ack_prev = 1'b0;
    logic [22:0] mon_adr = '0;
    logic [15:0] ack_dq = '0;
    logic        ack_dqoe = 1'b0;
    always @(negedge clk) begin
        ack_prev <= ack;
        if (!ce_n) begin
            n_ce    <= n_ce + 1;
            mon_adr <= s_adr;
            if (!ub_n) n_ub <= n_ub + 1;
            if (!lb_n) n_lb <= n_lb + 1;
        end
        if (!oe_n) n_oe <= n_oe + 1;
        if (!we_n) n_we <= n_we + 1;
        if (ack) begin
            n_ack    <= n_ack + 1;
            ack_dq   <= dq_o;
            ack_dqoe <= dq_oe;
            if (!ack_prev) n_rise <= n_rise + 1;
        end
    end

    function automatic logic [15:0] exp_read(input int a, input logic [1:0] s);
        logic [15:0] e;
        e = exp_mem.exists(a) ? exp_mem[a] : 16'h0000;
        return {s[1] ? e[15:8] : 8'h00, s[0] ? e[7:0] : 8'h00};
    endfunction

    function automatic void model_write(input int a, input logic [1:0] s,
                                        input logic [15:0] d);
        logic [15:0] e;
        e = exp_mem.exists(a) ? exp_mem[a] : 16'h0000;
        if (s[1]) e[15:8] = d[15:8];
        if (s[0]) e[7:0]  = d[7:0];
        exp_mem[a] = e;
    endfunction

    task automatic do_xfer(input logic [14:0] a, input logic w,
                           input logic [1:0] s, input logic [15:0] d,
                           output logic [15:0] rd, output int lat);
        rd  = '0;
        lat = -1;
        @(posedge clk); #1;
        adr = a; we = w; sel = s; wdat = d;
        vda = 1'b1; vpa = 1'b0; cyc = 1'b1; stb = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ack) begin
                lat = c;
                rd  = rdat;
                break;
            end
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; vda = 1'b0;
        wdat = $urandom; adr = $urandom; sel = $urandom;
    endtask

    task automatic gap();
        repeat (W + 5) @(posedge clk);
    endtask

    task automatic preload(input logic [14:0] a, input logic [15:0] d);
        logic [15:0] rd;
        int lat;
        do_xfer(a, 1'b1, 2'b11, d, rd, lat);
        model_write(int'(a), 2'b11, d);
        gap();
    endtask

    // Two requests with cyc held high; the second is presented right after
    // the first acknowledge, as the CPU does.
    task automatic do_pair(input logic [14:0] a0, input logic w0,
                           input logic [15:0] d0, input logic [14:0] a1,
                           output int c0, output int c1,
                           output logic [15:0] r1);
        int phase;
        logic hit;
        c0 = -1; c1 = -1; r1 = '0; phase = 0;
        @(posedge clk); #1;
        adr = a0; we = w0; sel = 2'b11; wdat = d0;
        vpa = 1'b1; cyc = 1'b1; stb = 1'b1;
        for (int c = 0; c < 60 && phase < 2; c++) begin
            @(negedge clk);
            hit = ack;
            if (hit) begin
                if (phase == 0) c0 = c;
                else begin
                    c1 = c;
                    r1 = rdat;
                end
                phase++;
            end
            @(posedge clk); #1;
            if (hit && phase == 1) begin
                adr = a1; we = 1'b0; wdat = $urandom;
            end else if (hit) begin
                cyc = 1'b0; stb = 1'b0;
            end
        end
        cyc = 1'b0; stb = 1'b0; vpa = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 res = 1'b0;
        @(negedge clk);
        checks++;
        if (ack !== 1'b0 || rdat !== 16'h0) begin
            errors++;
            $display("FAIL reset_bus ack=%b dat=%h want 0/0000", ack, rdat);
        end
        checks++;
        if ({ce_n, oe_n, we_n, ub_n, lb_n} !== 5'h1F || dq_oe !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl ctl=%b oe=%b want 11111/0",
                     {ce_n, oe_n, we_n, ub_n, lb_n}, dq_oe);
        end
        checks++;
        if (s_adr !== 23'h0 || dq_o !== 16'h0) begin
            errors++;
            $display("FAIL reset_adr adr=%h dq=%h want 0/0", s_adr, dq_o);
        end
    endtask

    task automatic test_reset_mid();
        int a0;
        preload(15'h0300, 16'h7E57);
        a0 = n_ack;
        @(posedge clk); #1;
        adr = 15'h0300; we = 1'b0; sel = 2'b11; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        res = 1'b1; cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        checks++;
        if (ce_n !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_active ce_n=%b want 0", ce_n);
        end
        @(posedge clk); #1;
        res = 1'b0;
        @(negedge clk);
        checks++;
        if ({ce_n, oe_n, we_n, ub_n, lb_n} !== 5'h1F || dq_oe !== 1'b0 ||
            ack !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_ctl ctl=%b oe=%b ack=%b want 11111/0/0",
                     {ce_n, oe_n, we_n, ub_n, lb_n}, dq_oe, ack);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (n_ack - a0 !== 0) begin
            errors++;
            $display("FAIL rst_mid_noack acks=%0d want 0", n_ack - a0);
        end
    endtask

    task automatic test_read();
        logic [15:0] rd;
        int lat, o0;
        preload(15'h1234, 16'hBEEF);
        o0 = n_oe;
        do_xfer(15'h1234, 1'b0, 2'b11, 16'h0, rd, lat);
        gap();
        checks++;
        if (lat !== RD_LAT) begin
            errors++;
            $display("FAIL read_lat got %0d want %0d", lat, RD_LAT);
        end
        checks++;
        if (rd !== exp_read(32'h1234, 2'b11)) begin
            errors++;
            $display("FAIL read_data got %h want %h", rd,
                     exp_read(32'h1234, 2'b11));
        end
        checks++;
        if (mon_adr !== 23'h001234) begin
            errors++;
            $display("FAIL read_adr got %h want 001234", mon_adr);
        end
        checks++;
        if (n_oe - o0 !== W + 1) begin
            errors++;
            $display("FAIL read_oe_len got %0d want %0d", n_oe - o0, W + 1);
        end
    endtask

    task automatic test_byte();
        logic [15:0] rd;
        int lat, w0, u0, l0;
        preload(15'h0040, 16'h125A);
        w0 = n_we; u0 = n_ub; l0 = n_lb;
        do_xfer(15'h0040, 1'b1, 2'b10, 16'hA55A, rd, lat);
        model_write(32'h40, 2'b10, 16'hA55A);
        gap();
        checks++;
        if (lat !== WR_LAT) begin
            errors++;
            $display("FAIL bwr_lat got %0d want %0d", lat, WR_LAT);
        end
        checks++;
        if (n_we - w0 !== W + 1 || n_ub - u0 !== W + 1 || n_lb - l0 !== 0) begin
            errors++;
            $display("FAIL bwr_strobes we=%0d ub=%0d lb=%0d want %0d/%0d/0",
                     n_we - w0, n_ub - u0, n_lb - l0, W + 1, W + 1);
        end
        checks++;
        if (ack_dq !== 16'hA55A || ack_dqoe !== 1'b1) begin
            errors++;
            $display("FAIL bwr_dq_hold dq=%h oe=%b want a55a/1", ack_dq, ack_dqoe);
        end
        do_xfer(15'h0040, 1'b0, 2'b01, 16'h0, rd, lat);
        gap();
        checks++;
        if (rd !== exp_read(32'h40, 2'b01)) begin
            errors++;
            $display("FAIL brd_lo got %h want %h", rd, exp_read(32'h40, 2'b01));
        end
        do_xfer(15'h0040, 1'b0, 2'b11, 16'h0, rd, lat);
        gap();
        checks++;
        if (rd !== exp_read(32'h40, 2'b11)) begin
            errors++;
            $display("FAIL brd_word got %h want %h", rd, exp_read(32'h40, 2'b11));
        end
    endtask

    task automatic test_sel_none();
        logic [15:0] rd;
        int lat, c0, u0, l0;
        c0 = n_ce; u0 = n_ub; l0 = n_lb;
        do_xfer(15'h0040, 1'b0, 2'b00, 16'h0, rd, lat);
        gap();
        checks++;
        if (lat !== RD_LAT || rd !== 16'h0) begin
            errors++;
            $display("FAIL sel0_read lat=%0d dat=%h want %0d/0000", lat, rd, RD_LAT);
        end
        checks++;
        if (n_ce - c0 !== W + 1 || n_ub - u0 !== 0 || n_lb - l0 !== 0) begin
            errors++;
            $display("FAIL sel0_strobes ce=%0d ub=%0d lb=%0d want %0d/0/0",
                     n_ce - c0, n_ub - u0, n_lb - l0, W + 1);
        end
    endtask

    task automatic test_abort();
        logic [15:0] rd;
        int lat, a0, c0;
        a0 = n_ack; c0 = n_ce;
        @(posedge clk); #1;
        adr = 15'h0040; we = 1'b0; sel = 2'b11; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc = 1'b0;
        repeat (12) @(negedge clk);
        stb = 1'b0;
        checks++;
        if (n_ack - a0 !== 0 || n_ce - c0 !== W + 1) begin
            errors++;
            $display("FAIL abort acks=%0d ce=%0d want 0/%0d",
                     n_ack - a0, n_ce - c0, W + 1);
        end
        do_xfer(15'h0040, 1'b0, 2'b11, 16'h0, rd, lat);
        gap();
        checks++;
        if (lat !== RD_LAT || rd !== exp_read(32'h40, 2'b11)) begin
            errors++;
            $display("FAIL abort_recover lat=%0d dat=%h want %0d/%h",
                     lat, rd, RD_LAT, exp_read(32'h40, 2'b11));
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] r1;
        int c0, c1, a0, p0;
        preload(15'h0000, 16'h1111);
        preload(15'h0001, 16'h2222);
        a0 = n_ack; p0 = n_rise;
        do_pair(15'h0000, 1'b0, 16'h0, 15'h0001, c0, c1, r1);
        gap();
        checks++;
        if (c0 !== RD_LAT || c1 !== 2 * W + 5) begin
            errors++;
            $display("FAIL b2b_timing acks at %0d,%0d want %0d,%0d",
                     c0, c1, RD_LAT, 2 * W + 5);
        end
        checks++;
        if (n_ack - a0 !== 2 || n_rise - p0 !== 2) begin
            errors++;
            $display("FAIL b2b_pulses ack_clocks=%0d pulses=%0d want 2/2",
                     n_ack - a0, n_rise - p0);
        end
        checks++;
        if (r1 !== exp_read(32'h1, 2'b11)) begin
            errors++;
            $display("FAIL b2b_data got %h want %h", r1, exp_read(32'h1, 2'b11));
        end
    endtask

    task automatic test_posted();
        logic [15:0] r1, d;
        int c0, c1;
        preload(15'h0100, 16'h0F0F);
        d = 16'($urandom);
        do_pair(15'h0100, 1'b1, d, 15'h0100, c0, c1, r1);
        model_write(32'h100, 2'b11, d);
        gap();
        checks++;
        if (c0 !== WR_LAT || c1 !== 2 * W + 5) begin
            errors++;
            $display("FAIL wr_rd_timing acks at %0d,%0d want %0d,%0d",
                     c0, c1, WR_LAT, 2 * W + 5);
        end
        checks++;
        if (r1 !== exp_read(32'h100, 2'b11)) begin
            errors++;
            $display("FAIL wr_rd_data got %h want %h", r1,
                     exp_read(32'h100, 2'b11));
        end
    endtask

    task automatic test_random();
        logic [15:0] rd, d;
        logic [14:0] a;
        logic [1:0]  s;
        logic        w;
        int lat;
        for (int i = 0; i < 8; i++) preload(15'(16'h0200 + i), 16'($urandom));
        for (int i = 0; i < 24; i++) begin
            a = 15'(16'h0200 + $urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            s = 2'($urandom_range(0, 3));
            d = 16'($urandom);
            do_xfer(a, w, s, d, rd, lat);
            gap();
            checks++;
            if (lat !== (w ? WR_LAT : RD_LAT)) begin
                errors++;
                $display("FAIL rnd_lat[%0d] we=%b got %0d want %0d",
                         i, w, lat, w ? WR_LAT : RD_LAT);
            end
            if (w) begin
                model_write(int'(a), s, d);
            end else begin
                checks++;
                if (rd !== exp_read(int'(a), s)) begin
                    errors++;
                    $display("FAIL rnd_data[%0d] adr=%h sel=%b got %h want %h",
                             i, a, s, rd, exp_read(int'(a), s));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_read();
        test_byte();
        test_sel_none();
        test_abort();
        test_back_to_back();
        test_posted();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_bridge_s16.md
Name: sram_bridge_s16

Overview:
- Bus responder (slave) for the STEAMER16X4 CPU's Wishbone-classic master port; maps word address, byte selects and data onto the Nexys2 16-bit asynchronous cellular RAM.
- Inserts a programmable number of wait states.
- Returns a single-cycle registered acknowledge.
- Sits between the CPU bus and the top-level SRAM pins; it is the only memory responder at this level.

Parameters:
- WAIT_STATES, 4, extra clocks the SRAM strobes are held beyond the minimum (0..15).
- RAM_ADR_HI, 23, top bit of the external SRAM word address; upper bits beyond adr_i[15:1] are driven 0.

Ports:
- clk_i  in  1  system clock
- res_i  in  1  synchronous, active-high reset
- adr_i  in  15  word address [15:1]
- we_i  in  1  1=write, 0=read
- cyc_i  in  1  bus cycle in progress
- stb_i  in  1  strobe; a request is cyc_i&stb_i
- sel_i  in  2  byte lanes: [1]=dat[15:8], [0]=dat[7:0]
- vda_i  in  1  data access qualifier; not used for decode, captured for debug only
- vpa_i  in  1  program access qualifier; not used for decode, captured for debug only
- dat_i  in  16  write data from CPU
- ack_o  out  1  cycle acknowledge, one clock wide
- dat_o  out  16  read data, valid while ack_o=1
- sram_adr_o  out  RAM_ADR_HI  SRAM word address
- sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_ub_n_o, sram_lb_n_o  out  1 each  active-low SRAM controls
- sram_dq_o  out  16  SRAM write data
- sram_dq_oe_o  out  1  1=bridge drives DQ (tristate at top level)
- sram_dq_i  in  16  SRAM read data

Behaviour:
- Reset (res_i=1 at an edge):
  - state=IDLE.
  - ack_o=0, dat_o=0.
  - All sram_*_n_o=1, sram_dq_oe_o=0, sram_adr_o=0, sram_dq_o=0.
  - Reset mid-access aborts immediately; no ack is issued.
- States:
  - IDLE:
    - At an edge with cyc_i&stb_i: latch adr, we, sel and dat_i; load cnt=WAIT_STATES; go to ACCESS.
    - Controls go active: ce_n=0; ub_n=~sel[1]; lb_n=~sel[0]; oe_n=we; we_n=~we; dq_oe=we.
  - ACCESS:
    - At each edge: if cnt==0, go to ACK (on reads, dat_o<=sram_dq_i, masked so unselected lanes read 0); else cnt<=cnt-1.
  - ACK:
    - ack_o=1 for exactly this clock.
    - ce_n/oe_n/we_n return to 1; address, dq_o and dq_oe are held one more clock for hold time.
    - Next edge goes to IDLE unconditionally, even if cyc_i is still 1. The CPU changes its request after sampling ack, so each request is captured only once.
- Latency, counting the first cycle the request is visible as 0:
  - ack_o is high in cycle WAIT_STATES+2.
  - One idle cycle minimum between back-to-back accesses.
- Outputs are registered; no combinational path from bus inputs to ack_o or dat_o.
- sel_i=00: the full timed cycle runs with ub_n=lb_n=1, ack is issued, and dat_o=0.
- cyc_i or stb_i dropping during ACCESS: the SRAM cycle completes, ack is suppressed, and the block returns to IDLE.
- adr_i, dat_i and sel_i changes after capture are ignored.

Optional Feature:
- Macro SRAMB_POSTED_WRITE_EN.
- Defined:
  - A write captured in IDLE goes to state POST; ack_o is high in cycle 2 regardless of WAIT_STATES.
  - The SRAM write completes in the background; the timing of POST plus ACCESS is the same as a normal write.
  - A request arriving while the posted write is busy is not captured until the write has finished its hold clock; it then proceeds normally.
  - Reads are unchanged.
- Undefined: writes take the same path and latency as reads.

Decomposition:
- Package sram_bridge_pkg:
  - state encoding (IDLE, ACCESS, ACK, POST)
  - SEL_HI, SEL_LO, SEL_WORD constants
  - WAIT_W = 4
- One natural sub-module, sramb_wait_ctr: loadable down-counter with a zero flag and a synchronous clear.

Test Plan:
- Reset asserted in ACCESS with WAIT_STATES=4 -> next clock all sram_*_n_o=1, dq_oe=0, ack_o=0; no ack afterwards.
- Read adr_i=15'h1234, sel=11, SRAM returns 16'hBEEF, WAIT_STATES=4 -> sram_adr_o=0x1234, oe_n=0 for 5 clocks, ack_o high in cycle 6 with dat_o=16'hBEEF.
- Byte write sel=10, dat_i=16'hA55A -> ub_n=0, lb_n=1, we_n=0 for 5 clocks, dq_o=16'hA55A held through ACK; byte read sel=01 of the same location -> dat_o=16'h005A (unselected lane forced to 0).
- Back-to-back fetch at 0x0000 then 0x0001, cyc_i held high -> exactly two ack pulses, each one clock; the second request is captured only after an IDLE clock.
- cyc_i dropped in the second ACCESS clock -> strobes complete, no ack, state returns to IDLE.
- With SRAMB_POSTED_WRITE_EN, write to 0x0100 followed immediately by a read of 0x0100 -> write ack in cycle 2; the read waits, then returns the written data.
